mem_access_stage: RTL

Consumer side of the EX/MEM pipeline register: takes the MEM-stage bundle (ALU result, store data, load/store/writeback controls), runs the data-memory request/ready handshake, stalls the upstream pipeline while the access is outstanding, and loads the MEM/WB register. Sits between the EX/MEM register outputs and the write-back stage. It owns all data-memory traffic for the 5-stage MIPS core.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_timeout_counter.sv | 39 +++
 rtl/mem_access_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the MEM stage and its helpers.
// Also imported by the instruction-fetch side for the timeout default.
package mem_stage_pkg;

    localparam int unsigned WORD_W                 = 32;
    localparam int unsigned REG_ADDR_W             = 5;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    // Payload of the MEM/WB pipeline register.
    typedef struct packed {
        logic                  valid;
        logic                  write_reg;
        logic [REG_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]     data;
    } wb_bundle_t;

    function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter: clear restarts it, enable counts one cycle, expired
// flags that TERMINAL_COUNT-1 has been reached. Saturates at the terminal value.
module mem_timeout_counter
    import mem_stage_pkg::*;
#(
    parameter int unsigned TERMINAL_COUNT = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TERMINAL_COUNT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired = (count_q == CNT_W'(TERMINAL_COUNT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage core: issues data-memory requests, stalls the
// front of the pipe while an access is outstanding and loads MEM/WB.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  mem_valid,
    input  logic [WORD_W-1:0]     mem_pc_4,
    input  logic                  mem_isJumpAndLink,
    input  logic [WORD_W-1:0]     mem_aluOutput,
    input  logic [WORD_W-1:0]     mem_registerRt,
    input  logic                  mem_shouldWriteMemory,
    input  logic                  mem_shouldWriteMemoryElseAluOutputToRegister,
    input  logic                  mem_shouldWriteRegister,
    input  logic [REG_ADDR_W-1:0] mem_registerWriteAddress,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [WORD_W-1:0]     dmem_addr,
    output logic [WORD_W-1:0]     dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [WORD_W-1:0]     dmem_rdata,
    output logic                  stall,
    output logic                  wb_valid,
    output logic                  wb_shouldWriteRegister,
    output logic [REG_ADDR_W-1:0] wb_registerWriteAddress,
    output logic [WORD_W-1:0]     wb_writeData,
    output logic                  align_error,
    output logic                  bus_error
);

    mem_state_e state_q;
    mem_state_e state_d;

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    wb_bundle_t        wb_q, wb_d;
    logic              align_err_q, align_err_d;
    logic              bus_err_q, bus_err_d;
    logic              stall_c;

    logic is_mem_op_c;
    logic is_store_c;
    logic aligned_c;
    logic timeout_expired;

    // A set store control wins over the load control.
    assign is_mem_op_c = mem_valid &
                         (mem_shouldWriteMemory | mem_shouldWriteMemoryElseAluOutputToRegister);
    assign is_store_c  = mem_valid & mem_shouldWriteMemory;
    assign aligned_c   = is_word_aligned(mem_aluOutput);

    mem_timeout_counter #(
        .TERMINAL_COUNT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_q == MEM_IDLE),
        .enable  ((state_q == MEM_BUSY) && !dmem_ready),
        .expired (timeout_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: begin
                if (is_mem_op_c && aligned_c) begin
                    state_d = MEM_BUSY;
                end
            end
            MEM_BUSY: begin
                if (dmem_ready || timeout_expired) begin
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    // MEM/WB defaults to a bubble; only completed instructions overwrite it.
    always_comb begin
        stall_c     = 1'b0;
        req_d       = 1'b0;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wb_d        = '0;
        align_err_d = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (is_mem_op_c) begin
                    if (aligned_c) begin
                        stall_c = 1'b1;
                        req_d   = 1'b1;
                        we_d    = is_store_c;
                        addr_d  = mem_aluOutput;
                        wdata_d = mem_registerRt;
                    end else begin
                        align_err_d = 1'b1;
                    end
                end else begin
                    wb_d.valid     = mem_valid;
                    wb_d.write_reg = mem_valid & mem_shouldWriteRegister;
                    wb_d.addr      = mem_registerWriteAddress;
                    wb_d.data      = mem_isJumpAndLink ? mem_pc_4 : mem_aluOutput;
                end
            end
            MEM_BUSY: begin
                req_d   = 1'b1;
                stall_c = !dmem_ready && !timeout_expired;
                if (dmem_ready) begin
                    req_d          = 1'b0;
                    wb_d.valid     = 1'b1;
                    wb_d.write_reg = !we_q && mem_shouldWriteRegister;
                    wb_d.addr      = mem_registerWriteAddress;
                    wb_d.data      = we_q ? WORD_W'(0) : dmem_rdata;
                end else if (timeout_expired) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                end
            end
            default: begin
                stall_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wb_q        <= '0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wb_q        <= wb_d;
            align_err_q <= align_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Stall is forced low while reset is held so the front end is never frozen.
    assign stall                   = stall_c & reset_n;
    assign dmem_req                = req_q;
    assign dmem_we                 = we_q;
    assign dmem_addr               = addr_q;
    assign dmem_wdata              = wdata_q;
    assign wb_valid                = wb_q.valid;
    assign wb_shouldWriteRegister  = wb_q.write_reg;
    assign wb_registerWriteAddress = wb_q.addr;
    assign wb_writeData            = wb_q.data;
    assign align_error             = align_err_q;
    assign bus_error               = bus_err_q;

endmodule
